dmem_mailbox_responder: RTL and testbench
=========================================

Name: dmem_mailbox_responder

Overview:
- Data-memory responder for the M3-stage store port of the four-issue pipeline.
- Accepts stores from the core and serves loads with one-cycle registered read latency.
- Decodes a store-based mailbox protocol into a sticky run status: PASS, FAIL or TIMEOUT.
- Instantiated in `top` in place of the plain data memory, so on-chip runs and FPGA runs report results without a testbench.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two; address bits [log2(DEPTH)+1:2] index the RAM.
- PASS_ADDR, 84, store byte address that signals completion.
- PASS_DATA, 7, data value that means success when stored to PASS_ADDR.
- SCRATCH_ADDR, 80, byte address the program may store to freely without ending the run.
- TIMEOUT_CYCLES, 4096, cycles after reset release without a verdict before TIMEOUT; 16-bit range.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- we3  in  1  store enable from M3.
- dataadrM3  in  32  byte address from M3, used for both loads and stores.
- writedata2M3  in  32  store data from M3.
- re3  in  1  load request from M3.
- readdataW  out  32  load data, valid one cycle after re3.
- rvalid  out  1  high for exactly one cycle when readdataW is valid.
- status  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
- done  out  1  high when status != RUN.
- store_count  out  16  number of accepted stores, saturating at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - status=RUN, done=0, readdataW=0, rvalid=0, store_count=0, cycle counter=0.
  - RAM contents are not cleared.
- Store acceptance:
  - A store is accepted when we3=1, status=RUN and dataadrM3[1:0]=00.
  - An accepted store writes writedata2M3 into RAM[index] at the rising edge and increments store_count (saturating).
  - A misaligned store (dataadrM3[1:0]!=00 with we3=1 in RUN) does not write RAM and moves status to FAIL.
- Address wrap: dataadrM3 bits above the index field are ignored, so addresses alias modulo 4*DEPTH. PASS_ADDR and SCRATCH_ADDR are compared on the full 32 bits.
- FSM, evaluated on every accepted store while in RUN:
  - addr==PASS_ADDR and data==PASS_DATA → PASS.
  - addr==PASS_ADDR and data!=PASS_DATA → FAIL.
  - addr==SCRATCH_ADDR → stay in RUN.
  - Any other address → FAIL.
  - The transition occurs at the same edge as the RAM write; the mailbox store itself is written and counted.
- Timeout:
  - The cycle counter increments every cycle in RUN.
  - When it reaches TIMEOUT_CYCLES-1 with no verdict, status becomes TIMEOUT at the next edge.
  - If a verdict store lands on that same edge, the verdict wins.
- PASS, FAIL and TIMEOUT are terminal until reset.
  - In terminal states stores are ignored: no RAM write, no count.
  - Loads are still served.
- Loads:
  - re3=1 at edge N gives readdataW=RAM[index] and rvalid=1 after edge N; rvalid returns to 0 after edge N+1 unless re3 is held.
  - Back-to-back loads return one result per cycle.
  - readdataW holds its last value when rvalid=0.
- Simultaneous store and load to the same index in the same cycle: the load returns the OLD data (read-before-write). Different indices are independent.
- Reset asserted mid-run: status and counters return to RUN/0 immediately (asynchronous). RAM keeps its contents, so a re-run can observe stale data.
- done is a direct decode of status; no extra latency.

Test Plan:
- Pass sequence: reset low 10 ns, then stores (80,1), (80,3), (84,7) → status=01 and done=1 on the edge of the 84 store; store_count=3.
- Fail on wrong data: store (84,6) → status=10; a later store (84,7) is ignored and status stays 10; store_count=1.
- Fail on stray address: store (88,5) → status=10; RAM[22] reads back 5 via re3 with rvalid one cycle later.
- Timeout: TIMEOUT_CYCLES=16, no stores after reset release → status=11 after exactly 16 edges. Variant with (84,7) on the 16th edge → status=01.
- Read-before-write: RAM[20]=0xA5 preloaded, store (80,0x5A) with re3 to 80 in the same cycle → readdataW=0xA5; the next load returns 0x5A.
- Reset mid-run: after (80,1), assert reset=0 between edges → status=00 and store_count=0 with no clock edge; after release, a load of 80 returns 1.

Source files
------------

// File: rtl/dmem_mailbox_responder_if.sv
// M3-stage data-memory bus between the core (master) and the mailbox responder (slave).
interface dmem_mailbox_responder_if;
  logic        we3;
  logic [31:0] dataadrM3;
  logic [31:0] writedata2M3;
  logic        re3;
  logic [31:0] readdataW;
  logic        rvalid;

  modport master (
    output we3, dataadrM3, writedata2M3, re3,
    input  readdataW, rvalid
  );

  modport slave (
    input  we3, dataadrM3, writedata2M3, re3,
    output readdataW, rvalid
  );
endinterface

// File: rtl/dmem_mailbox_responder.sv
// Data memory with one-cycle registered loads that also decodes mailbox stores
// into a sticky PASS / FAIL / TIMEOUT run status.
module dmem_mailbox_responder #(
  parameter int unsigned DEPTH          = 64,
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  dmem_mailbox_responder_if.slave       bus,
  output logic [1:0]                    status,
  output logic                          done,
  output logic [15:0]                   store_count
);

  localparam int unsigned IDX_W        = $clog2(DEPTH);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] store_count_q, store_count_d;
  logic [15:0] cycle_q, cycle_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;
  logic        ram_we;
  logic [IDX_W-1:0] idx;

  logic [31:0] ram_q [DEPTH];

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    store_count_d = store_count_q;
    cycle_d       = cycle_q;
    readdata_d    = readdata_q;
    rvalid_d      = bus.re3;
    ram_we        = 1'b0;
    idx           = bus.dataadrM3[IDX_W+1:2];

    // Loads are served in every state; readdata holds when idle.
    if (bus.re3) begin
      readdata_d = ram_q[idx];
    end

    if (state_q == ST_RUN) begin
      cycle_d = cycle_q + 16'd1;
      if (cycle_q == TIMEOUT_LAST) begin
        state_d = ST_TIMEOUT;
      end

      // A verdict store overrides a timeout landing on the same edge.
      if (bus.we3) begin
        if (bus.dataadrM3[1:0] == 2'b00) begin
          ram_we = 1'b1;
          if (store_count_q != 16'hFFFF) begin
            store_count_d = store_count_q + 16'd1;
          end
          if (bus.dataadrM3 == PASS_ADDR) begin
            state_d = (bus.writedata2M3 == PASS_DATA) ? ST_PASS : ST_FAIL;
          end else if (bus.dataadrM3 != SCRATCH_ADDR) begin
            state_d = ST_FAIL;
          end
        end else begin
          state_d = ST_FAIL;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      store_count_q <= '0;
      cycle_q       <= '0;
      readdata_q    <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      store_count_q <= store_count_d;
      cycle_q       <= cycle_d;
      readdata_q    <= readdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents
  // survive a reset and a re-run can observe stale data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[idx] <= bus.writedata2M3;
    end
  end

  assign bus.readdataW = readdata_q;
  assign bus.rvalid    = rvalid_q;
  assign status        = state_q;
  assign done          = (state_q != ST_RUN);
  assign store_count   = store_count_q;

endmodule

// File: tb/tb_dmem_mailbox_responder.sv
// Directed bench for dmem_mailbox_responder: load results are checked through
// a scoreboard queue, status/counters through immediate assertions.
module tb_dmem_mailbox_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  status;
  logic        done;
  logic [15:0] store_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  dmem_mailbox_responder_if bus ();

  dmem_mailbox_responder #(
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .status      (status),
    .done        (done),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic re, input logic [31:0] exp_rd);
    logic [31:0] exp_v;
    bus.we3          = we;
    bus.dataadrM3    = adr;
    bus.writedata2M3 = wd;
    bus.re3          = re;
    if (re) sb.push_back(exp_rd);
    @(posedge clk);
    #1;
    bus.we3 = 1'b0;
    bus.re3 = 1'b0;
    check("rvalid", {31'd0, bus.rvalid}, {31'd0, re});
    if (bus.rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {31'd0, bus.rvalid}, 32'd0);
      end else begin
        exp_v = sb.pop_front();
        check("readdataW", bus.readdataW, exp_v);
      end
    end else if (re && sb.size() != 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] wd);
    step(1'b1, adr, wd, 1'b0, 32'd0);
  endtask

  task automatic load(input logic [31:0] adr, input logic [31:0] exp_rd);
    step(1'b0, adr, 32'd0, 1'b1, exp_rd);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp_status, input logic [15:0] exp_count);
    check({tag, "_status"}, {30'd0, status}, {30'd0, exp_status});
    check({tag, "_done"}, {31'd0, done}, {31'd0, (exp_status != 2'b00)});
    check({tag, "_count"}, {16'd0, store_count}, {16'd0, exp_count});
  endtask

  // Assert reset away from the edge, check reset values, release before the next edge.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_state("rst", 2'b00, 16'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_readdata", bus.readdataW, 32'd0);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.we3          = 1'b0;
    bus.re3          = 1'b0;
    bus.dataadrM3    = '0;
    bus.writedata2M3 = '0;
    #10;
    check_state("init", 2'b00, 16'd0);
    check("init_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("init_readdata", bus.readdataW, 32'd0);
    #2;
    reset = 1'b1;

    // Pass sequence
    store(32'd80, 32'd1);
    check_state("pass_s1", 2'b00, 16'd1);
    store(32'd80, 32'd3);
    store(32'd84, 32'd7);
    check_state("pass", 2'b01, 16'd3);
    store(32'd80, 32'd9);
    check_state("pass_sticky", 2'b01, 16'd3);
    load(32'd80, 32'd3);

    // Misaligned store: no write, no count, FAIL
    apply_reset();
    store(32'd81, 32'd9);
    check_state("misalign", 2'b10, 16'd0);
    load(32'd80, 32'd3);

    // Wrong mailbox data, later stores ignored
    apply_reset();
    store(32'd84, 32'd6);
    check_state("fail_data", 2'b10, 16'd1);
    store(32'd84, 32'd7);
    check_state("fail_sticky", 2'b10, 16'd1);
    load(32'd84, 32'd6);

    // Stray address: written and counted, then FAIL
    apply_reset();
    store(32'd88, 32'd5);
    check_state("fail_addr", 2'b10, 16'd1);
    load(32'd88, 32'd5);

    // Aliased address writes RAM[20] but is not the scratch address
    apply_reset();
    store(32'd336, 32'h11);
    check_state("alias", 2'b10, 16'd1);
    load(32'd80, 32'h11);

    // Read-before-write, back-to-back loads, hold when idle
    apply_reset();
    store(32'd80, 32'hA5);
    step(1'b1, 32'd80, 32'h5A, 1'b1, 32'hA5);
    load(32'd80, 32'h5A);
    load(32'd84, 32'd6);
    idle();
    check("hold_readdata", bus.readdataW, 32'd6);
    check_state("rbw", 2'b00, 16'd2);

    // Asynchronous reset mid-run
    apply_reset();
    store(32'd80, 32'd1);
    check_state("mid_pre", 2'b00, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    check_state("mid_rst", 2'b00, 16'd0);
    #1;
    reset = 1'b1;
    load(32'd80, 32'd1);

    // Timeout after exactly 16 edges
    apply_reset();
    for (int i = 0; i < 15; i++) idle();
    check_state("to_pre", 2'b00, 16'd0);
    idle();
    check_state("timeout", 2'b11, 16'd0);
    store(32'd84, 32'd7);
    check_state("to_sticky", 2'b11, 16'd0);

    // Verdict on the 16th edge beats the timeout
    apply_reset();
    for (int i = 0; i < 15; i++) idle();
    store(32'd84, 32'd7);
    check_state("to_verdict", 2'b01, 16'd1);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
